// File: rtl/lcd_text_pipeline.sv
// lcd_text_pipeline: maps pixel coordinates to text cells, fetches character and glyph rows, and emits
// one monochrome pixel per input four clocks later, with a blinking cursor overlay.
module lcd_text_pipeline #(
   parameter int COLUMNS        = 100,
   parameter int ROWS           = 30,
   parameter int MAX_LOG2_SCALE = 2,
   parameter int BLINK_LOG2     = 5,
   parameter int TEXT_ADDR_W    = 12
)(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   input  logic [9:0]             x,
   input  logic [9:0]             y,
   input  logic [1:0]             scale,
   input  logic [5:0]             scroll_row,
   input  logic                   frame_start,
   input  logic                   cursor_enable,
   input  logic [6:0]             cursor_column,
   input  logic [5:0]             cursor_row,
   output logic [TEXT_ADDR_W-1:0] text_addr,
   input  logic [7:0]             text_data,
   output logic [11:0]            font_addr,
   input  logic [7:0]             font_data,
   output logic                   out_valid,
   output logic                   out_pixel
);
   localparam logic [7:0] COLS = 8'(COLUMNS);
   localparam logic [6:0] RWS  = 7'(ROWS);
   logic [1:0]             s;
   logic [9:0]             sx, sy;
   logic [6:0]             column;
   logic [5:0]             row, scr;
   logic [2:0]             char_col;
   logic [3:0]             char_row;
   logic                   in_range, cursor_hit;
   logic [6:0]             eff_sum, eff;
   logic [TEXT_ADDR_W-1:0] addr;
   logic [BLINK_LOG2:0]    blink, blink_next;
   logic [3:0]             vld, rng, hit;
   logic [3:0][2:0]        cc;
   logic [1:0][3:0]        cr;
   always_comb begin
      s          = (scale > 2'(MAX_LOG2_SCALE)) ? 2'(MAX_LOG2_SCALE) : scale;
      sx         = x >> s;
      sy         = y >> s;
      column     = sx[9:3];
      row        = sy[9:4];
      char_col   = sx[2:0];
      char_row   = sy[3:0];
      in_range   = ({1'b0, column} < COLS) && ({1'b0, row} < RWS);
      scr        = ({1'b0, scroll_row} >= RWS) ? 6'd0 : scroll_row;
      eff_sum    = {1'b0, row} + {1'b0, scr};
      eff        = (eff_sum >= RWS) ? eff_sum - RWS : eff_sum;
      addr       = TEXT_ADDR_W'(eff) * TEXT_ADDR_W'(COLUMNS) + TEXT_ADDR_W'(column);
      cursor_hit = cursor_enable && in_range && column == cursor_column && row == cursor_row;
      blink_next = blink + {{BLINK_LOG2{1'b0}}, frame_start};
   end
   // Cursor/blink decision is folded in at sampling time so later changes never touch in-flight pixels.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld       <= '0;
         rng       <= '0;
         hit       <= '0;
         cc        <= '0;
         cr        <= '0;
         text_addr <= '0;
         font_addr <= '0;
         out_valid <= 1'b0;
         out_pixel <= 1'b0;
         blink     <= '0;
      end else begin
         vld       <= {vld[2:0], in_valid};
         rng       <= {rng[2:0], in_range};
         hit       <= {hit[2:0], cursor_hit & blink_next[BLINK_LOG2]};
         cc        <= {cc[2:0], char_col};
         cr        <= {cr[0], char_row};
         text_addr <= in_range ? addr : '0;
         font_addr <= {text_data, cr[1]};
         out_valid <= vld[3];
         out_pixel <= vld[3] & ((rng[3] & font_data[~cc[3]]) ^ hit[3]);
         blink     <= blink_next;
      end
   end
endmodule

// File: tb/tb_lcd_text_pipeline.sv
// tb_lcd_text_pipeline: randomized and directed stimulus against a cell-level reference model,
// with a queue-based scoreboard checking pixel value and latency at the output.
module tb_lcd_text_pipeline;
   localparam int COLS = 100, ROWS = 30;
   logic        clock = 0, reset_n = 0;
   logic        in_valid = 0, frame_start = 0, cursor_enable = 0;
   logic [9:0]  x = 0, y = 0;
   logic [1:0]  scale = 0;
   logic [5:0]  scroll_row = 0, cursor_row = 0;
   logic [6:0]  cursor_column = 0;
   logic [11:0] text_addr, font_addr;
   logic [7:0]  text_data = 0, font_data = 0;
   logic        out_valid, out_pixel;

   lcd_text_pipeline dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .x(x), .y(y), .scale(scale),
      .scroll_row(scroll_row), .frame_start(frame_start), .cursor_enable(cursor_enable),
      .cursor_column(cursor_column), .cursor_row(cursor_row), .text_addr(text_addr),
      .text_data(text_data), .font_addr(font_addr), .font_data(font_data),
      .out_valid(out_valid), .out_pixel(out_pixel)
   );

   always #5 clock = ~clock;

   logic [7:0] tram [4096];
   logic [7:0] from [4096];
   always @(posedge clock) begin
      text_data <= tram[text_addr];
      font_data <= from[font_addr];
   end

   typedef struct { int pix; int due; } exp_t;
   exp_t q[$];
   exp_t e;
   int   cyc = 0, frames = 0, n_chk = 0, n_fail = 0;
   bit   pend_valid = 0;
   int   pend_addr = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference: plain division/modulo on the cell grid, scroll as a modular offset.
   function automatic void model(input int px, py, sc, scr, ce, ccol, crow,
                                 output int addr, output int pix);
      int s, sx, sy, col, row, c, r, sr, glyph, hitv, idx;
      bit inr;
      s     = (sc > 2) ? 2 : sc;
      sx    = px / (1 << s);
      sy    = py / (1 << s);
      col   = sx / 8;
      row   = sy / 16;
      c     = sx % 8;
      r     = sy % 16;
      inr   = (col < COLS) && (row < ROWS);
      sr    = (scr >= ROWS) ? 0 : scr;
      addr  = inr ? ((row + sr) % ROWS) * COLS + col : 0;
      idx   = int'(tram[addr]) * 16 + r;
      glyph = inr ? int'(from[idx][7 - c]) : 0;
      hitv  = (ce != 0 && inr && col == ccol && row == crow) ? 1 : 0;
      pix   = glyph ^ (hitv & ((frames >> 5) & 1));
   endfunction

   task automatic check_pend();
      if (pend_valid) chk("text_addr", int'(text_addr), pend_addr);
      pend_valid = 0;
   endtask

   task automatic drive(input bit v, input int px, py, sc, scr, input bit fs,
                        input bit ce, input int ccol, crow, want);
      int a, p;
      @(posedge clock); #1;
      check_pend();
      in_valid = v; x = 10'(px); y = 10'(py); scale = 2'(sc); scroll_row = 6'(scr);
      frame_start = fs; cursor_enable = ce; cursor_column = 7'(ccol); cursor_row = 6'(crow);
      if (fs) frames++;
      if (v) begin
         model(px, py, sc, scr, ce, ccol, crow, a, p);
         q.push_back('{pix: p, due: cyc + 5});
         pend_valid = 1;
         pend_addr  = (want >= 0) ? want : a;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      check_pend();
      in_valid = 0; frame_start = 0;
      reset_n = 0;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_pixel", int'(out_pixel), 0);
      chk("rst_text_addr", int'(text_addr), 0);
      chk("rst_font_addr", int'(font_addr), 0);
      q.delete();
      frames = 0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1;
   endtask

   always @(negedge clock) begin
      if (reset_n) begin
         if (out_valid) begin
            if (q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
               e = q.pop_front();
               chk("pixel", int'(out_pixel), e.pix);
               chk("latency", cyc, e.due);
            end
         end else begin
            chk("idle_pixel", int'(out_pixel), 0);
            if (q.size() > 0 && q[0].due <= cyc) begin
               chk("missing_valid", 0, 1);
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         tram[i] = 8'($urandom);
         from[i] = 8'($urandom);
      end
      tram[202] = 8'h41;
      from[12'h413] = 8'h40;
      tram[203] = 8'h00;
      for (int i = 0; i < 16; i++) from[i] = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_text_addr", int'(text_addr), 0);
      reset_n = 1;
      // single pixel: cell (2,2), char_col 1, char_row 3
      drive(1, 17, 35, 0, 0, 0, 0, 0, 0, 202);
      idle(3);
      chk("font_addr", int'(font_addr), 12'h413);
      idle(4);
      // scale clamp, scroll wrap, scroll ignored, out of range with cursor on column 100
      drive(1, 64, 64, 3, 0, 0, 0, 0, 0, 102);
      drive(1, 40, 464, 0, 5, 0, 0, 0, 0, 405);
      drive(1, 40, 464, 0, 40, 0, 0, 0, 0, 2905);
      drive(1, 800, 35, 0, 0, 0, 1, 100, 2, 0);
      drive(1, 1023, 1023, 0, 0, 0, 1, 100, 63, 0);
      idle(6);
      for (int i = 0; i < 200; i++) begin
         int px, py;
         if (i == 120) do_reset();
         px = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 95) : $urandom_range(0, 1023);
         py = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 95) : $urandom_range(0, 1023);
         drive($urandom_range(0, 3) != 0, px, py, $urandom_range(0, 3), $urandom_range(0, 63),
               $urandom_range(0, 15) == 0, $urandom_range(0, 1) != 0,
               $urandom_range(0, 11), $urandom_range(0, 5), -1);
      end
      do_reset();
      // blink: counter restarts from zero, phase flips on the 32nd frame_start
      drive(1, 24, 32, 0, 0, 0, 1, 3, 2, 203);
      for (int f = 1; f <= 34; f++) begin
         drive(1, 24, 32, 0, 0, 1, 1, 3, 2, 203);
         drive(1, 32, 32, 0, 0, 0, 1, 3, 2, 204);
      end
      idle(8);
      chk("drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/lcd_text_pipeline.md
Name: lcd_text_pipeline

Overview:
Parametrised, pipelined text-mode pixel generator for the LCD path. It maps each incoming pixel coordinate to a character cell, using a runtime-selectable scale, a hardware row scroll, and configurable screen dimensions. It then fetches the character code from the text RAM and the glyph row from the font ROM, and emits one monochrome pixel per input with a fixed latency. A blinking cursor overlay is included. The block sits between the LCD timing generator and the colour mux.

Parameters:
COLUMNS, 100, text columns on screen (1..128)
ROWS, 30, text rows on screen (1..64)
MAX_LOG2_SCALE, 2, largest accepted scale input
BLINK_LOG2, 5, cursor blink half-period = 2^BLINK_LOG2 frames
TEXT_ADDR_W, 12, text RAM address width; must satisfy 2^TEXT_ADDR_W >= COLUMNS*ROWS

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  pixel coordinate valid this cycle
x  in  10  pixel x
y  in  10  pixel y
scale  in  2  log2 scale factor, sampled with each pixel
scroll_row  in  6  text row shown at the top of the screen
frame_start  in  1  one-cycle pulse at start of frame
cursor_enable  in  1  cursor overlay on
cursor_column  in  7  cursor screen column
cursor_row  in  6  cursor screen row (pre-scroll)
text_addr  out  TEXT_ADDR_W  text RAM read address
text_data  in  8  character code; synchronous RAM, valid one clock after text_addr
font_addr  out  12  {char code[7:0], glyph row[3:0]} to font ROM
font_data  in  8  glyph row bits, bit 7 = leftmost pixel; valid one clock after font_addr
out_valid  out  1  out_pixel valid
out_pixel  out  1  1 = foreground

Behaviour:
- Reset (async assert, sync-release by the system): all pipeline valid flags, text_addr, font_addr, out_valid, out_pixel, and the blink counter go to 0.
- Reset mid-operation discards in-flight pixels; no out_valid occurs for pixels accepted before reset.
- Scale: s = min(scale, MAX_LOG2_SCALE). sx = x >> s and sy = y >> s, both logical shifts at 10 bits.
- Cell mapping: column = sx[9:3], row = sy[9:4], char_col = sx[2:0], char_row = sy[3:0].
- In-range test: in_range = (column < COLUMNS) && (row < ROWS).
- Scroll: scroll_row >= ROWS is treated as 0. eff_row = row + scroll_row; if eff_row >= ROWS, subtract ROWS (single wrap).
- Addressing: text_addr = eff_row*COLUMNS + column when in_range, else 0.
- Pipeline, with the pixel sampled at edge k:
  - Edge k: text_addr registered; column, row, char_col, char_row and in_range are delayed alongside.
  - Edge k+2: font_addr registered from {text_data, char_row}.
  - Edge k+4: out_valid and out_pixel registered. Latency is exactly 4 clocks.
- Throughput: one pixel per clock, no stall. in_valid gaps propagate as out_valid gaps. Side-band data travels with the valid bit.
- Pixel value: glyph = font_data[7 - char_col] when in_range, else 0.
- Cursor: cursor_hit = cursor_enable && in_range && column == cursor_column && row == cursor_row. The comparison uses screen row, not eff_row.
- Output: out_pixel = glyph XOR (cursor_hit && blink_phase). When out_valid = 0, out_pixel = 0.
- Blink: a BLINK_LOG2+1 bit counter increments on each frame_start and wraps naturally; blink_phase = counter MSB.
- Blink timing: the counter updates on the edge where frame_start = 1, so the pixel sampled on that same edge already sees the new phase.
- Simultaneous frame_start and in_valid are both honoured.
- scale, scroll_row and the cursor inputs are sampled with each pixel at edge k. Changes take effect on the next accepted pixel, with no glitching of pixels already in flight.

Test Plan:
- Reset then single pixel: x=17, y=35, scale=0, scroll=0. Expect text_addr = 2*100 + 2 = 202. With text_data = 0x41 → font_addr = 0x413. With font_data = 0x40 → out_pixel = 1 (bit 6 for char_col 1), out_valid exactly 4 clocks after in_valid.
- Scale clamp: x=64, y=64, scale=3 → treated as s=2. Column 2, row 1, text_addr = 102.
- Scroll wrap: y=29*16, scroll_row=5 → eff_row = 4, text_addr = 400 + column. scroll_row = 40 → behaves as 0.
- Out of range: x=800 (column 100). Expect text_addr = 0, out_pixel = 0 regardless of font_data, out_valid still 1. Cursor at column 100 never inverts.
- Cursor blink: cursor at (3,2), enabled, BLINK_LOG2=5, glyph = 0. out_pixel is 0 for frames 0–31 and 1 after the 32nd frame_start; non-cursor cells are unaffected.
- Streaming and reset: 200 back-to-back pixels with random gaps produce a matching out_valid pattern delayed 4 clocks. Asserting reset_n=0 mid-stream drops out_valid to 0 immediately and zeroes the blink counter.
